// File: rtl/sb_pkg.sv
// +------------------------------------------------------------------+
// | sb_pkg : shared mode encodings, entry type and size helpers      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package sb_pkg;

  localparam logic [2:0] c_MODE_BYTE  = 3'b000;
  localparam logic [2:0] c_MODE_HALF  = 3'b001;
  localparam logic [2:0] c_MODE_WORD  = 3'b010;
  localparam logic [2:0] c_MODE_UBYTE = 3'b011;
  localparam logic [2:0] c_MODE_UHALF = 3'b100;
  localparam logic [2:0] c_MODE_IDLE  = 3'b111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mode;
  } sb_entry_t;

  function automatic logic [2:0] mode_size(input logic [2:0] mode);
    case (mode)
      c_MODE_BYTE, c_MODE_UBYTE: return 3'd1;
      c_MODE_HALF, c_MODE_UHALF: return 3'd2;
      default:                   return 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] size_class(input logic [2:0] mode);
    case (mode)
      c_MODE_BYTE, c_MODE_UBYTE: return 2'd0;
      c_MODE_HALF, c_MODE_UHALF: return 2'd1;
      default:                   return 2'd2;
    endcase
  endfunction

  // Only signed byte/half and word are valid store widths.
  function automatic logic store_legal(input logic [2:0] mode);
    return (mode == c_MODE_BYTE) || (mode == c_MODE_HALF) || (mode == c_MODE_WORD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_extend.sv
// +------------------------------------------------------------------+
// | sb_extend : sign/zero extension of forwarded store data          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sb_extend
  import sb_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  mode,
  output logic [31:0] result
);

  always_comb begin
    result = data;
    case (mode)
      c_MODE_BYTE:  result = {{24{data[7]}}, data[7:0]};
      c_MODE_UBYTE: result = {24'd0, data[7:0]};
      c_MODE_HALF:  result = {{16{data[15]}}, data[15:0]};
      c_MODE_UHALF: result = {16'd0, data[15:0]};
      default:      result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// +------------------------------------------------------------------+
// | store_buffer : posted-store FIFO owning the data-memory port;    |
// | loads bypass unless they overlap a pending store.                |
// | Option macro SB_FWD_EN enables store-to-load forwarding.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mode,
  output logic        req_ready,
  output logic [31:0] resp_rdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_mode,
  input  logic [31:0] mem_rdata,
  output logic        sb_empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  sb_entry_t            r_entries [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_CNT_W-1:0]   r_count;

  logic [DEPTH-1:0]     w_hit;
  logic                 w_full;
  logic                 w_overlap;
  logic                 w_fwd;
  logic [31:0]          w_fwd_data;
  logic                 w_load_ok;
  logic                 w_load_acc;
  logic                 w_mem_load;
  logic                 w_drain;
  logic                 w_push;
  logic [32:0]          w_ld_lo;
  logic [32:0]          w_ld_hi;
  sb_entry_t            w_head_e;

  assign w_full   = (r_count == c_CNT_W'(DEPTH));
  assign w_ld_lo  = {1'b0, req_addr};
  assign w_ld_hi  = w_ld_lo + 33'(mode_size(req_mode));
  assign w_head_e = r_entries[r_head];

  // 33-bit range compare so a top-of-memory entry never wraps to address 0.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [c_PTR_W-1:0] w_off;
    logic [32:0]        w_lo;
    logic [32:0]        w_hi;
    assign w_off    = c_PTR_W'(i) - r_head;
    assign w_lo     = {1'b0, r_entries[i].addr};
    assign w_hi     = w_lo + 33'(mode_size(r_entries[i].mode));
    assign w_hit[i] = ({1'b0, w_off} < r_count) && store_legal(r_entries[i].mode)
                      && (w_lo < w_ld_hi) && (w_ld_lo < w_hi);
  end

  assign w_overlap = |w_hit;

`ifdef SB_FWD_EN
  logic [c_PTR_W-1:0] w_young;
  logic [c_PTR_W-1:0] w_age_idx;
  sb_entry_t          w_young_e;

  // Walk oldest to youngest so the last hit seen is the youngest.
  always_comb begin
    w_young   = '0;
    w_age_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_age_idx = r_head + c_PTR_W'(k);
      if (w_hit[w_age_idx]) w_young = w_age_idx;
    end
  end

  assign w_young_e = r_entries[w_young];
  assign w_fwd = w_overlap && (w_young_e.addr == req_addr)
                 && (size_class(w_young_e.mode) == size_class(req_mode));

  sb_extend u_extend (
    .data   (w_young_e.wdata),
    .mode   (req_mode),
    .result (w_fwd_data)
  );
`else
  assign w_fwd      = 1'b0;
  assign w_fwd_data = '0;
`endif

  assign w_load_ok  = !w_full && (!w_overlap || w_fwd);
  assign req_ready  = (req_valid && !req_we) ? w_load_ok : !w_full;
  assign w_load_acc = req_valid && !req_we && w_load_ok;
  assign w_mem_load = w_load_acc && !w_fwd;
  assign w_drain    = (r_count != '0) && !w_mem_load;
  assign w_push     = req_valid && req_we && !w_full;
  assign sb_empty   = (r_count == '0);

  always_comb begin
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_mode   = c_MODE_IDLE;
    resp_rdata = '0;
    if (w_mem_load) begin
      mem_rd_en  = 1'b1;
      mem_addr   = req_addr;
      mem_mode   = req_mode;
      resp_rdata = mem_rdata;
    end else begin
      if (w_load_acc) resp_rdata = w_fwd_data;
      // Illegal-mode entries still pop but never reach memory.
      if (w_drain && store_legal(w_head_e.mode)) begin
        mem_wr_en = 1'b1;
        mem_addr  = w_head_e.addr;
        mem_wdata = w_head_e.wdata;
        mem_mode  = w_head_e.mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + c_PTR_W'(1);
      if (w_drain) r_head <= r_head + c_PTR_W'(1);
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_entries[r_tail] <= '{addr: req_addr, wdata: req_wdata, mode: req_mode};
  end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// +------------------------------------------------------------------+
// | tb_store_buffer : directed + random checks against a queue model |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mode;
  logic        req_ready;
  logic [31:0] resp_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_mode;
  logic [31:0] mem_rdata;
  logic        sb_empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mode(req_mode), .req_ready(req_ready),
    .resp_rdata(resp_rdata), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .mem_rdata(mem_rdata), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mode;
  } ent_t;

  ent_t       sbq[$];
  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         m_push, m_drain, exp_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] m);
    case (m)
      3'b000, 3'b011: return 1;
      3'b001, 3'b100: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] m);
    return m <= 3'b010;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [2:0] m);
    case (m)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b011:  return {24'd0, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {16'd0, r[15:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] m);
    logic [31:0] raw = '0;
    logic [7:0]  idx;
    for (int k = 0; k < sz(m); k++) begin
      idx = 8'(a + 32'(k));
      raw[8*k +: 8] = ref_mem[idx];
    end
    return extend(raw, m);
  endfunction

  // Environment memory: asynchronous read, write qualified by mem_wr_en.
  always_comb begin
    logic [31:0] raw;
    logic [7:0]  idx;
    raw = '0;
    for (int k = 0; k < sz(mem_mode); k++) begin
      idx = 8'(mem_addr + 32'(k));
      raw[8*k +: 8] = env_mem[idx];
    end
    mem_rdata = extend(raw, mem_mode);
  end

  always @(posedge clk) begin
    if (mem_wr_en)
      for (int k = 0; k < sz(mem_mode); k++)
        env_mem[8'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
  end

  task automatic eval_and_check();
    bit          full, ovl, fwd, acc, mload, e_wr, e_rd;
    int          y;
    logic [63:0] ea, la;
    logic [31:0] e_addr, e_wd, e_resp;
    logic [2:0]  e_mode;
    full = (sbq.size() == DEPTH);
    y    = -1;
    la   = {32'd0, req_addr};
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      ea = {32'd0, sbq[i].addr};
      if (legal(sbq[i].mode) && ea < la + 64'(sz(req_mode)) && la < ea + 64'(sz(sbq[i].mode))) begin
        y = i;
        break;
      end
    end
    ovl = (y >= 0);
    fwd = 1'b0;
`ifdef SB_FWD_EN
    if (ovl) fwd = (sbq[y].addr == req_addr) && (sz(sbq[y].mode) == sz(req_mode));
`endif
    exp_ready = (req_valid && !req_we) ? (!full && (!ovl || fwd)) : !full;
    acc     = req_valid && !req_we && exp_ready;
    mload   = acc && !fwd;
    m_drain = (sbq.size() > 0) && !mload;
    m_push  = req_valid && req_we && !full;
    e_wr = 0; e_rd = 0; e_addr = '0; e_wd = '0; e_mode = 3'b111; e_resp = '0;
    if (mload) begin
      e_rd = 1; e_addr = req_addr; e_mode = req_mode; e_resp = ref_read(req_addr, req_mode);
    end else begin
      if (acc) e_resp = extend(sbq[y].data, req_mode);
      if (m_drain && legal(sbq[0].mode)) begin
        e_wr = 1; e_addr = sbq[0].addr; e_wd = sbq[0].data; e_mode = sbq[0].mode;
      end
    end
    check("req_ready", req_ready, exp_ready);
    check("sb_empty", sb_empty, sbq.size() == 0);
    check("mem_wr_en", mem_wr_en, e_wr);
    check("mem_rd_en", mem_rd_en, e_rd);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("mem_mode", mem_mode, e_mode);
    check("resp_rdata", resp_rdata, e_resp);
  endtask

  task automatic drive(input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] m);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_mode = m;
    #3;
    eval_and_check();
  endtask

  task automatic clock_edge();
    logic [7:0] idx;
    if (m_drain) begin
      if (legal(sbq[0].mode))
        for (int k = 0; k < sz(sbq[0].mode); k++) begin
          idx = 8'(sbq[0].addr + 32'(k));
          ref_mem[idx] = sbq[0].data[8*k +: 8];
        end
      void'(sbq.pop_front());
    end
    if (m_push) sbq.push_back('{addr: req_addr, data: req_wdata, mode: req_mode});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 32'd0, 32'd0, 3'b000);
    clock_edge();
  endtask

  task automatic do_reset();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_mode = '0;
    rst_n = 0;
    #2;
    check("rst_empty", sb_empty, 1);
    check("rst_ready", req_ready, 1);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_mode", mem_mode, 3'b111);
    check("rst_resp", resp_rdata, 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    bit          hold;
    logic [31:0] ra, rd;
    logic [2:0]  rm;
    bit          rv, rw;
    logic [2:0]  lmodes [2];
    logic [31:0] fwd_exp [2];
    for (int i = 0; i < 256; i++) begin env_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst_n = 0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_mode = '0;
    @(posedge clk); #1;
    do_reset();

    // Single word store drains on the following edge.
    drive(1, 1, 32'h10, 32'hDEADBEEF, 3'b010); clock_edge();
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    check("beef_wr_en", mem_wr_en, 1);
    check("beef_addr", mem_addr, 32'h10);
    check("beef_mode", mem_mode, 3'b010);
    clock_edge();
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    check("beef_empty", sb_empty, 1);
    clock_edge();

    // Back-to-back stores, written in order.
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, 1, 32'h50 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010);
      clock_edge();
    end
    idle_cycle(); idle_cycle();

    // Overlapping load stalls until the byte store has drained.
    drive(1, 1, 32'h21, 32'h7F, 3'b000); clock_edge();
    drive(1, 0, 32'h20, 32'h0, 3'b010);
    check("ovl_stall", req_ready, 0);
    clock_edge();
    drive(1, 0, 32'h20, 32'h0, 3'b010);
    check("ovl_ready", req_ready, 1);
    check("ovl_data", resp_rdata, 32'h0000_7F00);
    clock_edge();
    idle_cycle();

    // Halfword store then signed / unsigned halfword loads of the same address.
    lmodes[0] = 3'b001; fwd_exp[0] = 32'hFFFF_8001;
    lmodes[1] = 3'b100; fwd_exp[1] = 32'h0000_8001;
    for (int j = 0; j < 2; j++) begin
      drive(1, 1, 32'h40, 32'h1234_8001, 3'b001); clock_edge();
      drive(1, 0, 32'h40, 32'h0, lmodes[j]);
`ifdef SB_FWD_EN
      check("fwd_ready", req_ready, 1);
      check("fwd_rd_en", mem_rd_en, 0);
      check("fwd_data", resp_rdata, fwd_exp[j]);
      clock_edge();
`else
      check("nofwd_stall", req_ready, 0);
      clock_edge();
      drive(1, 0, 32'h40, 32'h0, lmodes[j]);
      check("nofwd_data", resp_rdata, fwd_exp[j]);
      clock_edge();
`endif
      idle_cycle();
    end

    // Non-overlapping load takes the port; drain waits one cycle.
    drive(1, 1, 32'h10, 32'h5555_AAAA, 3'b010); clock_edge();
    drive(1, 0, 32'h80, 32'h0, 3'b010);
    check("bypass_ready", req_ready, 1);
    check("bypass_rd_en", mem_rd_en, 1);
    check("bypass_wr_defer", mem_wr_en, 0);
    clock_edge();
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    check("deferred_wr", mem_wr_en, 1);
    clock_edge();

    // Reset discards a pending store.
    drive(1, 1, 32'h90, 32'hCAFE_F00D, 3'b010); clock_edge();
    do_reset();
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    check("post_rst_wr", mem_wr_en, 0);
    check("post_rst_mode", mem_mode, 3'b111);
    clock_edge();

    // Illegal store mode is accepted and then dropped.
    drive(1, 1, 32'h98, 32'h1111_2222, 3'b011); clock_edge();
    drive(0, 0, 32'h0, 32'h0, 3'b000);
    check("illegal_pending", sb_empty, 0);
    check("illegal_no_wr", mem_wr_en, 0);
    clock_edge();

    // Top-of-memory byte must not alias with address 0.
    drive(1, 1, 32'hFFFF_FFFF, 32'hAB, 3'b000); clock_edge();
    drive(1, 0, 32'h0, 32'h0, 3'b000);
    check("nowrap_ready", req_ready, 1);
    clock_edge();
    idle_cycle();

    // Random traffic; a stalled request is held until accepted.
    hold = 0; rv = 0; rw = 0; ra = '0; rd = '0; rm = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold && ($urandom % 250 == 0)) begin
        do_reset();
        continue;
      end
      if (!hold) begin
        rv = ($urandom % 4) != 0;
        rw = $urandom % 2;
        ra = ($urandom % 8 == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                 : 32'h100 + 32'($urandom_range(0, 11));
        rd = $urandom;
        if (rw) rm = ($urandom % 10 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        else    rm = 3'($urandom_range(0, 4));
      end
      drive(rv, rw, ra, rd, rm);
      hold = rv && !exp_ready;
      clock_edge();
    end
    for (int i = 0; i < DEPTH + 2; i++) idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
